// File: rtl/conv3x3_scheduler.sv
// rtl/conv3x3_scheduler.sv - sequencer for a full valid-mode 3x3 convolution over an IFM image
module conv3x3_scheduler #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int AW    = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          ifm_rd_en,
  output logic [AW-1:0] ifm_addr,
  input  logic [7:0]    ifm_rdata,
  output logic          w_rd_en,
  output logic [3:0]    w_addr,
  input  logic [7:0]    w_rdata,
  output logic          weight_valid,
  output logic [71:0]   weight_data,
  output logic          in_valid,
  output logic [71:0]   win_data,
  input  logic          conv_out_valid,
  input  logic [20:0]   conv_out,
  output logic          ofm_we,
  output logic [AW-1:0] ofm_addr,
  output logic [20:0]   ofm_wdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LD_W,
    S_SEND_W,
    S_FETCH,
    S_ISSUE,
    S_DRAIN,
    S_FIN
  } state_t;

  localparam logic [AW-1:0] LP_W      = AW'(IMG_W);
  localparam logic [AW-1:0] LP_LAST_C = AW'(IMG_W - 3);
  localparam logic [AW-1:0] LP_LAST_R = AW'(IMG_H - 3);
  localparam logic [AW-1:0] LP_TOTAL  = AW'((IMG_W - 2) * (IMG_H - 2));

  state_t        r_state;
  state_t        w_next;
  // r_k counts 0..8 issuing reads, then one extra step (9) to capture the last byte
  logic [3:0]    r_k;
  logic [AW-1:0] r_row;
  logic [AW-1:0] r_col;
  logic [AW-1:0] r_ofm_cnt;
  logic [71:0]   r_weight_data;
  logic [71:0]   r_win_data;
  logic          r_ofm_we;
  logic [AW-1:0] r_ofm_addr;
  logic [20:0]   r_ofm_wdata;

  logic          w_seq_done;
  logic          w_last_win;
  logic [1:0]    w_roff;
  logic [3:0]    w_coff;
  logic [AW-1:0] w_pix_addr;

  assign w_seq_done = (r_k == 4'd9);
  assign w_last_win = (r_row == LP_LAST_R) && (r_col == LP_LAST_C);

  // Split the in-window index k into row/column offsets (row-major window walk)
  always_comb begin
    w_roff = 2'd0;
    if (r_k >= 4'd6)      w_roff = 2'd2;
    else if (r_k >= 4'd3) w_roff = 2'd1;
    w_coff     = r_k - ({2'b00, w_roff} + {1'b0, w_roff, 1'b0});
    w_pix_addr = (r_row + AW'(w_roff)) * LP_W + r_col + AW'(w_coff);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state and strobe decode
  always_comb begin
    w_next       = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    w_rd_en      = 1'b0;
    ifm_rd_en    = 1'b0;
    weight_valid = 1'b0;
    in_valid     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_LD_W;
      end
      S_LD_W: begin
        busy    = 1'b1;
        w_rd_en = (r_k < 4'd9);
        if (w_seq_done) w_next = S_SEND_W;
      end
      S_SEND_W: begin
        busy         = 1'b1;
        weight_valid = 1'b1;
        w_next       = S_FETCH;
      end
      S_FETCH: begin
        busy      = 1'b1;
        ifm_rd_en = (r_k < 4'd9);
        if (w_seq_done) w_next = S_ISSUE;
      end
      S_ISSUE: begin
        busy     = 1'b1;
        in_valid = 1'b1;
        w_next   = w_last_win ? S_DRAIN : S_FETCH;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (r_ofm_cnt == LP_TOTAL) w_next = S_FIN;
      end
      S_FIN: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Addresses are driven only while the matching read strobe is high
  assign w_addr      = w_rd_en ? r_k : 4'd0;
  assign ifm_addr    = ifm_rd_en ? w_pix_addr : '0;
  assign weight_data = r_weight_data;
  assign win_data    = r_win_data;
  assign ofm_we      = r_ofm_we;
  assign ofm_addr    = r_ofm_addr;
  assign ofm_wdata   = r_ofm_wdata;

  // Read sequencing, byte capture and window position
  always_ff @(posedge clk) begin
    if (rst) begin
      r_k           <= 4'd0;
      r_row         <= '0;
      r_col         <= '0;
      r_weight_data <= '0;
      r_win_data    <= '0;
    end else begin
      if (r_state == S_LD_W || r_state == S_FETCH) r_k <= w_seq_done ? 4'd0 : r_k + 4'd1;
      else                                         r_k <= 4'd0;
      // Byte k returns one cycle after its read, i.e. while r_k == k+1
      for (int i = 0; i < 9; i++) begin
        if (r_state == S_LD_W && r_k == 4'(i + 1))  r_weight_data[8*i +: 8] <= w_rdata;
        if (r_state == S_FETCH && r_k == 4'(i + 1)) r_win_data[8*i +: 8]    <= ifm_rdata;
      end
      if (r_state == S_IDLE && start) begin
        r_row <= '0;
        r_col <= '0;
      end else if (r_state == S_ISSUE) begin
        if (r_col == LP_LAST_C) begin
          r_col <= '0;
          r_row <= r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
    end
  end

  // Result path: register each datapath result into an OFM write at the running address
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ofm_we    <= 1'b0;
      r_ofm_addr  <= '0;
      r_ofm_wdata <= '0;
      r_ofm_cnt   <= '0;
    end else begin
      r_ofm_we <= 1'b0;
      if (r_state == S_IDLE) begin
        if (start) r_ofm_cnt <= '0;
      end else if (conv_out_valid) begin
        r_ofm_we    <= 1'b1;
        r_ofm_wdata <= conv_out;
        r_ofm_addr  <= r_ofm_cnt;
        r_ofm_cnt   <= r_ofm_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_conv3x3_scheduler.sv
// tb/tb_conv3x3_scheduler.sv - directed self-checking bench for conv3x3_scheduler
module tb_conv3x3_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, a_start, b_start, a_force, b_force;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  // instance A: 5x5 image
  logic        a_busy, a_done, a_ifm_rd_en, a_w_rd_en, a_weight_valid, a_in_valid, a_ofm_we;
  logic [11:0] a_ifm_addr, a_ofm_addr;
  logic [7:0]  a_ifm_rdata, a_w_rdata;
  logic [3:0]  a_w_addr;
  logic [71:0] a_weight_data, a_win_data, a_dp_w;
  logic        a_cov, a_p1_v, a_conv_out_valid;
  logic [20:0] a_cout, a_p1_sum, a_ofm_wdata;

  // instance B: 3x3 image
  logic        b_busy, b_done, b_ifm_rd_en, b_w_rd_en, b_weight_valid, b_in_valid, b_ofm_we;
  logic [11:0] b_ifm_addr, b_ofm_addr;
  logic [7:0]  b_ifm_rdata, b_w_rdata;
  logic [3:0]  b_w_addr;
  logic [71:0] b_weight_data, b_win_data, b_dp_w;
  logic        b_cov, b_p1_v, b_conv_out_valid;
  logic [20:0] b_cout, b_p1_sum, b_ofm_wdata;

  assign a_conv_out_valid = a_cov | a_force;
  assign b_conv_out_valid = b_cov | b_force;

  conv3x3_scheduler #(.IMG_W(5), .IMG_H(5), .AW(12)) u_a (
    .clk(clk), .rst(rst), .start(a_start), .busy(a_busy), .done(a_done),
    .ifm_rd_en(a_ifm_rd_en), .ifm_addr(a_ifm_addr), .ifm_rdata(a_ifm_rdata),
    .w_rd_en(a_w_rd_en), .w_addr(a_w_addr), .w_rdata(a_w_rdata),
    .weight_valid(a_weight_valid), .weight_data(a_weight_data),
    .in_valid(a_in_valid), .win_data(a_win_data),
    .conv_out_valid(a_conv_out_valid), .conv_out(a_cout),
    .ofm_we(a_ofm_we), .ofm_addr(a_ofm_addr), .ofm_wdata(a_ofm_wdata)
  );

  conv3x3_scheduler #(.IMG_W(3), .IMG_H(3), .AW(12)) u_b (
    .clk(clk), .rst(rst), .start(b_start), .busy(b_busy), .done(b_done),
    .ifm_rd_en(b_ifm_rd_en), .ifm_addr(b_ifm_addr), .ifm_rdata(b_ifm_rdata),
    .w_rd_en(b_w_rd_en), .w_addr(b_w_addr), .w_rdata(b_w_rdata),
    .weight_valid(b_weight_valid), .weight_data(b_weight_data),
    .in_valid(b_in_valid), .win_data(b_win_data),
    .conv_out_valid(b_conv_out_valid), .conv_out(b_cout),
    .ofm_we(b_ofm_we), .ofm_addr(b_ofm_addr), .ofm_wdata(b_ofm_wdata)
  );

  logic [7:0] a_img [0:24];
  logic [7:0] a_wt  [0:8];
  logic [7:0] b_img [0:8];
  logic [7:0] b_wt  [0:8];

  function automatic logic [20:0] dot(input logic [71:0] x, input logic [71:0] w);
    logic [20:0] s;
    s = 21'd0;
    for (int k = 0; k < 9; k++) s = s + 21'(x[8*k +: 8]) * 21'(w[8*k +: 8]);
    return s;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // synchronous-read memories and a two-cycle datapath for each instance
  always @(posedge clk) begin
    if (a_ifm_rd_en) a_ifm_rdata <= a_img[a_ifm_addr[4:0]];
    if (a_w_rd_en)   a_w_rdata   <= a_wt[a_w_addr];
    if (b_ifm_rd_en) b_ifm_rdata <= b_img[b_ifm_addr[3:0]];
    if (b_w_rd_en)   b_w_rdata   <= b_wt[b_w_addr];
    if (a_weight_valid) a_dp_w <= a_weight_data;
    if (b_weight_valid) b_dp_w <= b_weight_data;
    a_p1_v   <= a_in_valid;
    a_p1_sum <= dot(a_win_data, a_dp_w);
    a_cov    <= a_p1_v;
    a_cout   <= a_p1_sum;
    b_p1_v   <= b_in_valid;
    b_p1_sum <= dot(b_win_data, b_dp_w);
    b_cov    <= b_p1_v;
    b_cout   <= b_p1_sum;
  end

  int          a_wr_n, a_iv_n, a_done_n, a_both, a_ra_n;
  int          a_wv_cyc, a_first_iv, a_last_iv, a_done_cyc;
  logic        a_busy_at_done;
  logic [11:0] a_wr_addr [0:31];
  logic [20:0] a_wr_data [0:31];
  logic [11:0] a_ra [0:8];
  int          b_wr_n, b_iv_n, b_done_n, b_wv_cyc, b_first_iv, b_done_cyc;
  logic [11:0] b_wr_addr;
  logic [20:0] b_wr_data;

  // event recorder, sampled mid-cycle
  always @(negedge clk) begin
    if (a_ofm_we && a_wr_n < 32) begin
      a_wr_addr[a_wr_n] = a_ofm_addr;
      a_wr_data[a_wr_n] = a_ofm_wdata;
      a_wr_n++;
    end
    if (a_in_valid) begin
      if (a_iv_n == 0) a_first_iv = cyc;
      a_last_iv = cyc;
      a_iv_n++;
    end
    if (a_ifm_rd_en && a_ra_n < 9) begin
      a_ra[a_ra_n] = a_ifm_addr;
      a_ra_n++;
    end
    if (a_weight_valid) a_wv_cyc = cyc;
    if (a_done) begin
      a_done_n++;
      a_done_cyc = cyc;
      a_busy_at_done = a_busy;
    end
    if (a_ifm_rd_en && a_w_rd_en) a_both++;
    if (b_ofm_we) begin
      b_wr_addr = b_ofm_addr;
      b_wr_data = b_ofm_wdata;
      b_wr_n++;
    end
    if (b_in_valid) begin
      if (b_iv_n == 0) b_first_iv = cyc;
      b_iv_n++;
    end
    if (b_weight_valid) b_wv_cyc = cyc;
    if (b_done) begin
      b_done_n++;
      b_done_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clr_a();
    @(posedge clk);
    #1;
    a_wr_n = 0; a_iv_n = 0; a_done_n = 0; a_both = 0; a_ra_n = 0;
    a_wv_cyc = 0; a_first_iv = 0; a_last_iv = 0; a_done_cyc = 0; a_busy_at_done = 1'b1;
  endtask

  task automatic load_a(input int mode);
    for (int i = 0; i < 25; i++) a_img[i] = (mode == 0) ? 8'd1 : 8'(i);
    for (int i = 0; i < 9; i++)  a_wt[i]  = (mode == 0) ? 8'd1 : ((i == 4) ? 8'd1 : 8'd0);
  endtask

  task automatic start_a(output int s);
    @(negedge clk);
    a_start = 1'b1;
    s = cyc;
    @(negedge clk);
    a_start = 1'b0;
  endtask

  task automatic wait_done_a(input int max, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (a_done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_ramp(input string tag, input int base);
    int exp_r[9] = '{6, 7, 8, 11, 12, 13, 16, 17, 18};
    for (int i = 0; i < 9; i++) begin
      check($sformatf("%s_addr%0d", tag, i), 32'(a_wr_addr[base+i]), 32'(i));
      check($sformatf("%s_data%0d", tag, i), 32'(a_wr_data[base+i]), 32'(exp_r[i]));
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   s, s2;
    logic ok;
    int   exp_a[9] = '{0, 1, 2, 5, 6, 7, 10, 11, 12};

    rst = 1'b1; a_start = 1'b0; b_start = 1'b0; a_force = 1'b0; b_force = 1'b0;
    a_dp_w = '0; b_dp_w = '0;
    load_a(0);
    for (int i = 0; i < 9; i++) begin b_img[i] = 8'd255; b_wt[i] = 8'd255; end
    b_wr_n = 0; b_iv_n = 0; b_done_n = 0;
    repeat (3) @(negedge clk);

    // reset state
    check("rst_ctl_a", 32'({a_busy, a_done, a_ifm_rd_en, a_w_rd_en, a_weight_valid, a_in_valid, a_ofm_we}), 0);
    check("rst_data_a", 32'(|{a_weight_data, a_win_data, a_ofm_wdata}), 0);
    check("rst_addr_a", 32'({a_ifm_addr, a_ofm_addr, a_w_addr}), 0);
    check("rst_ctl_b", 32'({b_busy, b_done, b_ifm_rd_en, b_w_rd_en, b_weight_valid, b_in_valid, b_ofm_we}), 0);
    @(negedge clk);
    rst = 1'b0;

    // all-ones 5x5
    clr_a();
    start_a(s);
    wait_done_a(300, ok);
    check("t1_done_seen", 32'(ok), 1);
    repeat (2) @(negedge clk);
    check("t1_wr_n", a_wr_n, 9);
    for (int i = 0; i < 9; i++) begin
      check($sformatf("t1_addr%0d", i), 32'(a_wr_addr[i]), 32'(i));
      check($sformatf("t1_data%0d", i), 32'(a_wr_data[i]), 9);
    end
    check("t1_iv_n", a_iv_n, 9);
    check("t1_done_lat", a_done_cyc - a_last_iv, 4);
    check("t1_wv_cyc", a_wv_cyc - s, 11);
    check("t1_first_iv", a_first_iv - s, 22);
    check("t1_done_abs", a_done_cyc - s, 114);
    check("t1_busy_at_done", 32'(a_busy_at_done), 0);
    check("t1_rd_overlap", a_both, 0);

    // ramp image, centre-only kernel
    load_a(1);
    clr_a();
    start_a(s);
    wait_done_a(300, ok);
    check("t2_done_seen", 32'(ok), 1);
    repeat (2) @(negedge clk);
    check("t2_wr_n", a_wr_n, 9);
    check_ramp("t2", 0);
    for (int i = 0; i < 9; i++) check($sformatf("t2_raddr%0d", i), 32'(a_ra[i]), 32'(exp_a[i]));

    // 3x3 all-255
    @(negedge clk);
    b_start = 1'b1;
    s = cyc;
    @(negedge clk);
    b_start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (b_done) begin ok = 1'b1; break; end
    end
    check("t3_done_seen", 32'(ok), 1);
    repeat (2) @(negedge clk);
    check("t3_wr_n", b_wr_n, 1);
    check("t3_addr", 32'(b_wr_addr), 0);
    check("t3_data", 32'(b_wr_data), 32'h8EE09);
    check("t3_wv_cyc", b_wv_cyc - s, 11);
    check("t3_first_iv", b_first_iv - s, 22);
    check("t3_done_abs", b_done_cyc - s, 26);

    // start while busy, with done, and one cycle after done
    load_a(0);
    clr_a();
    start_a(s);
    repeat (40) @(negedge clk);
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    wait_done_a(300, ok);
    check("t4_done1_seen", 32'(ok), 1);
    a_start = 1'b1;
    check("t4_wr_at_done", a_wr_n, 9);
    check("t4_done1_abs", cyc - s, 114);
    @(negedge clk);
    s2 = cyc;
    check("t4_idle_after_done", 32'(a_busy), 0);
    @(negedge clk);
    a_start = 1'b0;
    check("t4_restart_busy", 32'(a_busy), 1);
    wait_done_a(300, ok);
    check("t4_done2_seen", 32'(ok), 1);
    check("t4_done2_abs", cyc - s2, 114);
    repeat (2) @(negedge clk);
    check("t4_wr_n", a_wr_n, 18);
    check("t4_done_n", a_done_n, 2);
    for (int i = 0; i < 9; i++) begin
      check($sformatf("t4_addr%0d", i), 32'(a_wr_addr[9+i]), 32'(i));
      check($sformatf("t4_data%0d", i), 32'(a_wr_data[9+i]), 9);
    end

    // reset during FETCH of window 4
    load_a(1);
    clr_a();
    start_a(s);
    while (cyc < s + 58) @(negedge clk);
    check("t5_in_fetch", 32'(a_ifm_rd_en), 1);
    rst = 1'b1;
    @(negedge clk);
    check("t5_rst_ctl", 32'({a_busy, a_done, a_ifm_rd_en, a_w_rd_en, a_weight_valid, a_in_valid, a_ofm_we}), 0);
    check("t5_rst_data", 32'(|{a_weight_data, a_win_data, a_ofm_wdata}), 0);
    check("t5_rst_addr", 32'({a_ifm_addr, a_ofm_addr, a_w_addr}), 0);
    rst = 1'b0;
    repeat (150) @(negedge clk);
    check("t5_no_done", a_done_n, 0);
    check("t5_pre_rst_wr", a_wr_n, 4);
    clr_a();
    start_a(s);
    wait_done_a(300, ok);
    check("t5_done_seen", 32'(ok), 1);
    repeat (2) @(negedge clk);
    check("t5_wr_n", a_wr_n, 9);
    check_ramp("t5", 0);

    // conv_out_valid forced while idle
    clr_a();
    @(negedge clk);
    a_force = 1'b1;
    repeat (5) @(negedge clk);
    a_force = 1'b0;
    @(negedge clk);
    check("t6_no_write", a_wr_n, 0);
    check("t6_ofm_addr_hold", 32'(a_ofm_addr), 8);
    check("t6_busy", 32'(a_busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/conv3x3_scheduler.md
# conv3x3_scheduler

Sequencer that runs a full 2-D valid-mode 3×3 convolution over an IMG_H×IMG_W 8-bit image using the team's single-window 3×3 convolution datapath. It reads the nine kernel weights and then every 3×3 window from synchronous-read memories and issues them to the datapath. It collects the 21-bit results and writes them in raster order to an output feature-map memory. The block sits between the IFM/weight SRAMs and the convolution datapath, under a host `start`/`done` handshake.

## Interface

- IMG_W, default 8, image width in pixels, must be ≥3
- IMG_H, default 8, image height in pixels, must be ≥3
- AW, default 12, address width of the IFM and OFM memories
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
- start  in  1  pulse that begins a job; sampled only in IDLE
- busy  out  1  high from the cycle after an accepted start until `done`
- done  out  1  one-cycle pulse when the last OFM word has been written
- ifm_rd_en  out  1  IFM memory read strobe
- ifm_addr  out  AW  IFM address, raster order, `row*IMG_W+col`
- ifm_rdata  in  8  IFM data, valid one cycle after `ifm_rd_en`
- w_rd_en  out  1  weight memory read strobe
- w_addr  out  4  weight index 0..8
- w_rdata  in  8  weight data, valid one cycle after `w_rd_en`
- weight_valid  out  1  one-cycle strobe to the datapath, `weight_data` valid
- weight_data  out  72  byte k, bits `[8k+7:8k]`, goes to datapath weight k+1
- in_valid  out  1  one-cycle strobe to the datapath, `win_data` valid
- win_data  out  72  byte k goes to datapath IFM k+1
- conv_out_valid  in  1  datapath result strobe
- conv_out  in  21  datapath result
- ofm_we  out  1  OFM write strobe
- ofm_addr  out  AW  OFM address, 0..`(IMG_W-2)*(IMG_H-2)-1`
- ofm_wdata  out  21  OFM write data

## Operation

- States: IDLE, LD_W, SEND_W, FETCH, ISSUE, DRAIN, FIN.
- **IDLE:** `start`=1 moves to LD_W and clears the window row/column counters (r,c) and the OFM address counter. `start` is ignored in every other state.
- **LD_W:** 9 cycles with `w_rd_en`=1 and `w_addr`=0..8. Each returned byte is registered into `weight_data` byte k. After the last capture, go to SEND_W.
- **SEND_W:** `weight_valid`=1 for exactly one cycle, then go to FETCH. Weights are sent once per job.
- **FETCH:** 9 reads at k=0..8, with `ifm_addr`=`(r+k/3)*IMG_W+(c+k%3)`, i.e. window row-major. Byte k is registered into `win_data` byte k. After the last capture, go to ISSUE.
- **ISSUE:** `in_valid`=1 for one cycle, then advance the window.
  - c increments; at c=IMG_W-3, c wraps to 0 and r increments.
  - If the issued window was the last one (r=IMG_H-3, c=IMG_W-3), go to DRAIN; otherwise go to FETCH.
- **Result path:** every `conv_out_valid` produces, one cycle later, `ofm_we`=1 with `ofm_wdata`=`conv_out` and `ofm_addr`=counter, then the counter increments. This path runs in every state except IDLE. `conv_out_valid` in IDLE is ignored.
- **DRAIN:** wait until the counter equals `(IMG_W-2)*(IMG_H-2)`, then go to FIN.
- **FIN:** `done`=1 and `busy`=0 for one cycle, then go to IDLE.
- `win_data` and `weight_data` hold their values between strobes.
- The block does no arithmetic on results. The result width is 21 bits, which is enough for 9×255×255 = 585225.

## Timing

- **Reset:** all outputs are 0, state is IDLE, and all counters and data registers are 0. Reset in any state aborts the job on the next edge; no `done` is produced and any pending write is dropped.
- `busy` rises the cycle after `start` is sampled.
- **Weight load:** `w_rd_en` is high in cycles 1-9 after start. `weight_valid` is high in cycle 11.
- **Window period:** 11 cycles, made of 9 read cycles, 1 capture cycle, and 1 `in_valid` cycle. `ifm_rd_en` for the first window begins in cycle 12.
- **Datapath contract:** `conv_out_valid` arrives 2 cycles after `in_valid`. The resulting `ofm_we` occurs 3 cycles after `in_valid`.
- **End of job:** with the final `in_valid` at cycle T, the final `ofm_we` is at T+3, `done` is at T+4, and `busy` falls at T+4.
- `start` asserted in the same cycle as `done` is ignored. `start` in the cycle after `done` is accepted.
- `ifm_rd_en` and `w_rd_en` are never high together. At most one `in_valid` is outstanding at any time.

## Test plan

- **All-ones image and weights, IMG_W=IMG_H=5:** exactly 9 `ofm_we` at addresses 0..8, each with value 9; `done` 4 cycles after the 9th `in_valid`.
- **Ramp image `pix=row*5+col` with a centre-only weight of 1 (others 0), 5×5:** OFM = 6,7,8,11,12,13,16,17,18. Check `ifm_addr` of the first window is 0,1,2,5,6,7,10,11,12.
- **All 255 with all weights 255, 3×3:** a single write of 585225 (0x8EE09) at address 0. Check the `weight_valid` cycle and the first `in_valid` cycle relative to `start`.
- **`start` pulsed while busy, and together with `done`:** both are ignored; the write count is unchanged. A `start` one cycle after `done` runs a second identical job.
- **`rst` asserted mid-FETCH of window 4, 5×5:** next cycle all outputs are 0 and `busy` is 0. No `done` appears. A fresh `start` reproduces the full 9-result sequence from address 0.
- **`conv_out_valid` forced high while IDLE:** no `ofm_we` and no counter change.
